bram_dump_reader: RTL
=====================

// Module: bram_dump_reader
// PURPOSE
//  Read-side counterpart of the testbench/loader BRAM write path: streams a contiguous
//  window of a bram32 instance (typically data BRAM) out as a byte stream for
//  post-run checking (UART TX or bench monitor). Drives the BRAM read port while the
//  core is stalled; emits each 32-bit word as 4 bytes over a valid/ready handshake.
// PARAMETERS
//  ADDR_WIDTH   10   byte-address width of the BRAM read port
//  DATA_WIDTH   32   BRAM word width (`DATA_WIDTH); must be a multiple of 8
//  CNT_WIDTH    9    width of word_count (max words per dump = 2^CNT_WIDTH-1)
// PORTS
//  clk         in   1            system clock, all logic on rising edge
//  rst         in   1            asynchronous, active-low reset
//  start       in   1            request dump; sampled only in IDLE
//  base_addr   in   ADDR_WIDTH   first byte address; bits [1:0] ignored (forced 0)
//  word_count  in   CNT_WIDTH    number of words to dump
//  busy        out  1            high from accepted start until done pulse
//  done        out  1            single-cycle pulse: dump finished
//  r_addr      out  ADDR_WIDTH   BRAM read address (word aligned)
//  r_enb       out  1            BRAM read enable
//  r_dat       in   DATA_WIDTH   BRAM read data, valid 1 cycle after r_enb
//  tx_data     out  8            byte being offered
//  tx_valid    out  1            tx_data valid
//  tx_ready    in   1            sink accepts byte when tx_valid & tx_ready at edge
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; busy, done, r_enb, tx_valid = 0; r_addr, tx_data = 0;
//   counters cleared. Reset mid-dump aborts immediately, no done pulse.
//  FSM: IDLE -> READ -> WAIT -> SEND -> (READ | FIN) ; FIN -> IDLE.
//   IDLE: start=1 & word_count!=0 -> latch addr={base_addr[ADDR_WIDTH-1:2],2'b00},
//         remaining=word_count, busy=1, go READ. start=1 & word_count==0 -> FIN.
//   READ: r_enb=1, r_addr=addr for exactly one cycle; go WAIT.
//   WAIT: r_enb=0; at edge capture r_dat into shift register; byte_idx=0; go SEND.
//   SEND: tx_valid=1, tx_data=byte[byte_idx], little-endian (bits 7:0 first).
//         On tx_valid&tx_ready: byte_idx++. On acceptance of byte 3: remaining--,
//         addr+=4 (wraps modulo 2^ADDR_WIDTH); remaining becomes 0 -> FIN else READ.
//   FIN:  done=1 for one cycle, busy=0 in same cycle; go IDLE.
//  Handshake: tx_data stable and tx_valid held while tx_valid & !tx_ready; tx_valid
//   never depends combinationally on tx_ready; tx_valid=0 outside SEND.
//  Latency: start edge N -> r_enb high in cycle N+1 -> first tx_valid in cycle N+3.
//   With tx_ready tied high: 6 cycles per word; done asserted 1 cycle after last byte.
//  start asserted while busy is ignored (no restart, no queuing).
//  r_dat is sampled only in WAIT; BRAM changes in other cycles have no effect.
//  Address wrap: base 0x3FC, 2 words -> reads 0x3FC then 0x000.
// STRUCTURE
//  Shared include rv32i_params.vh: DATA_WIDTH, D_BRAM address width constant;
//   add DUMP_IDLE/READ/WAIT/SEND/FIN state encodings (3-bit) to rv32i_control.vh.
//  One sub-module: word_byte_serializer (load word, shift out bytes under
//   valid/ready, reports last-byte accept); FSM and address/count in top.
// TESTING  (bench: bram32 instance preloaded via write port, this block on read port)
//  1 mem[0x0..0x8]={00000005,00000001,DEADBEEF}, base 0, count 3, ready=1 -> bytes
//    05 00 00 00 01 00 00 00 EF BE AD DE in order, done at 18 cycles+1 after start.
//  2 Same, tx_ready toggled 1-of-3 random -> identical byte sequence; tx_data never
//    changes while valid&!ready; exactly 12 handshakes.
//  3 word_count=0 -> no r_enb, no tx_valid, done pulse 1 cycle after start.
//  4 base 0x3FE (unaligned), count 2 -> r_addr sequence 0x3FC, 0x000.
//  5 start re-pulsed while busy -> ignored, single done; rst=0 mid-SEND -> all outputs
//    0 asynchronously, no done, next start dumps from new base correctly.

Source files
------------

// File: rtl/bram_dump_reader_pkg.sv
// Shared types and defaults for the BRAM dump reader.
// State encodings and byte-lane sizing helper.
package bram_dump_reader_pkg;

  typedef enum logic [2:0] {
    DUMP_IDLE = 3'd0,
    DUMP_READ = 3'd1,
    DUMP_WAIT = 3'd2,
    DUMP_SEND = 3'd3,
    DUMP_FIN  = 3'd4
  } dump_state_e;

  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 9;

  function automatic int unsigned idx_w(
    input int unsigned nbytes
  );
    return (nbytes > 2) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/bram_dump_reader_serializer.sv
// Loads one BRAM word and shifts it out LSB byte first
// under a valid/ready handshake; flags the last-byte accept.
module word_byte_serializer
  import bram_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [7:0]            byte_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned IW = idx_w(NB);

  logic [DATA_WIDTH-1:0] sh_q;
  logic [IW-1:0]         idx_q;
  logic                  valid_q;
  logic                  fire;

  assign fire    = valid_q & ready_i;
  assign last_o  = fire && (idx_q == IW'(NB - 1));
  assign byte_o  = sh_q[7:0];
  assign valid_o = valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      sh_q    <= word_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      sh_q    <= sh_q >> 8;
      idx_q   <= idx_q + 1'b1;
      if (last_o)
        valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bram_dump_reader.sv
// Streams a word window of a BRAM read port out as bytes
// (little-endian) for post-run checking.
module bram_dump_reader
  import bram_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_enb,
  input  logic [DATA_WIDTH-1:0] r_dat,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(4);

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  load;
  logic                  last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DUMP_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    busy    = 1'b0;
    done    = 1'b0;
    r_enb   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      DUMP_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d  = base_addr & ALIGN;
            rem_d   = word_count;
            state_d = DUMP_READ;
          end else begin
            state_d = DUMP_FIN;
          end
        end
      end
      DUMP_READ: begin
        busy    = 1'b1;
        r_enb   = 1'b1;
        state_d = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        busy    = 1'b1;
        load    = 1'b1;
        state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        busy = 1'b1;
        if (last) begin
          rem_d   = rem_q - 1'b1;
          addr_d  = addr_q + STEP;
          state_d = (rem_q == CNT_WIDTH'(1)) ? DUMP_FIN : DUMP_READ;
        end
      end
      DUMP_FIN: begin
        done    = 1'b1;
        state_d = DUMP_IDLE;
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  assign r_addr = addr_q;

  // r_dat is only captured on the WAIT edge via load
  word_byte_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .word_i (r_dat),
    .byte_o (tx_data),
    .valid_o(tx_valid),
    .ready_i(tx_ready),
    .last_o (last)
  );

endmodule
